axis_client_tx: RTL and testbench

//  Upstream source stage for the rolling-sum adder. Accepts operand words from the client

---
 rtl/axis_client_tx_pkg.sv | 15 +
 rtl/axis_client_tx_sync_fifo.sv | 43 ++++
 rtl/axis_client_tx.sv | 108 ++++++++++
 tb/tb_axis_client_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_client_tx_pkg.sv
// Shared types and constants for the client-side AXI-Stream source stage.
package axis_client_tx_pkg;

  localparam int unsigned DATAW_DEF          = 128;
  localparam int unsigned AXIS_MAX_DATAW_DEF = 512;
  localparam int unsigned PKT_LEN_W          = 16;
  localparam int unsigned WORDS_W            = 32;
  localparam int unsigned PKTS_W             = 16;

  typedef enum logic {
    StIdle   = 1'b0,
    StStream = 1'b1
  } tx_state_e;

endpackage

// File: rtl/axis_client_tx_sync_fifo.sv
// Synchronous FIFO with one extra pointer bit to tell full from empty.
module axis_client_tx_sync_fifo #(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/axis_client_tx.sv
// Client push port -> FIFO -> registered AXI-Stream output with packet length limiting
// and beat/packet counters.
module axis_client_tx
  import axis_client_tx_pkg::*;
#(
  parameter int unsigned DATAW          = DATAW_DEF,
  parameter int unsigned AXIS_MAX_DATAW = AXIS_MAX_DATAW_DEF,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned MAX_PKT_WORDS  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATAW-1:0]          client_tdata,
  input  logic                      client_tlast,
  input  logic                      client_valid,
  output logic                      client_ready,
  output logic                      axis_client_interface_tvalid,
  output logic                      axis_client_interface_tlast,
  output logic [AXIS_MAX_DATAW-1:0] axis_client_interface_tdata,
  input  logic                      axis_client_interface_tready,
  output logic [WORDS_W-1:0]        words_sent,
  output logic [PKTS_W-1:0]         pkts_sent,
  output logic                      err_forced_last
);

  logic                 active_q;
  logic [PKT_LEN_W-1:0] pkt_len_q;
  logic                 err_q;
  logic                 tvalid_q, tlast_q;
  logic [DATAW-1:0]     data_q;
  logic [WORDS_W-1:0]   words_q;
  logic [PKTS_W-1:0]    pkts_q;
  tx_state_e            state_q;

  logic             push, pop, beat, last_eff, limit_hit;
  logic             fifo_full, fifo_empty;
  logic [DATAW:0]   head;

  // active_q keeps client_ready low until the first edge after reset release.
  assign client_ready = active_q && !fifo_full;
  assign push         = client_valid && client_ready;
  assign beat         = tvalid_q && axis_client_interface_tready;
  assign pop          = !fifo_empty && (!tvalid_q || axis_client_interface_tready);
  assign limit_hit    = (MAX_PKT_WORDS != 0) &&
                        (pkt_len_q == PKT_LEN_W'(MAX_PKT_WORDS - 1));
  assign last_eff     = client_tlast || limit_hit;

  axis_client_tx_sync_fifo #(
    .WIDTH (DATAW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({last_eff, client_tdata}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      active_q  <= 1'b0;
      pkt_len_q <= '0;
      err_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      data_q    <= '0;
      words_q   <= '0;
      pkts_q    <= '0;
      state_q   <= StIdle;
    end else begin
      active_q <= 1'b1;
      if (push) begin
        pkt_len_q <= last_eff ? '0 : pkt_len_q + PKT_LEN_W'(1);
        if (limit_hit && !client_tlast) err_q <= 1'b1;
      end
      if (pop) begin
        tvalid_q <= 1'b1;
        tlast_q  <= head[DATAW];
        data_q   <= head[DATAW-1:0];
      end else if (beat) begin
        tvalid_q <= 1'b0;
      end
      if (beat) begin
        words_q <= words_q + WORDS_W'(1);
        if (tlast_q) pkts_q <= pkts_q + PKTS_W'(1);
        state_q <= tlast_q ? StIdle : StStream;
      end
    end
  end

  assign axis_client_interface_tvalid = tvalid_q;
  assign axis_client_interface_tlast  = tlast_q;
  assign axis_client_interface_tdata  = {{(AXIS_MAX_DATAW - DATAW){1'b0}}, data_q};
  assign words_sent                   = words_q;
  assign pkts_sent                    = pkts_q;
  assign err_forced_last              = err_q;

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (tvalid_q && !axis_client_interface_tready) |=>
    (tvalid_q && $stable(data_q) && $stable(tlast_q)));

  a_fsm_stream: assert property (@(posedge clk) disable iff (!rst)
    (beat && !tlast_q) |=> (state_q == StStream));

endmodule

// File: tb/tb_axis_client_tx.sv
// Directed bench for axis_client_tx; a second instance runs with a 4-word packet limit.
module tb_axis_client_tx;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] client_tdata = '0;
  logic         client_tlast = 1'b0;
  logic         client_valid = 1'b0;
  logic         tready = 1'b0;

  logic         client_ready, tvalid, tlast, err;
  logic [511:0] tdata;
  logic [31:0]  words;
  logic [15:0]  pkts;
  logic         client_ready4, tvalid4, tlast4, err4;
  logic [511:0] tdata4;
  logic [31:0]  words4;
  logic [15:0]  pkts4;

  int n_assert = 0;
  int n_fail   = 0;
  int mlen     = 0;
  logic [128:0] exp_q[$];
  logic [128:0] got_q[$];
  logic [128:0] got4_q[$];

  always #5 clk = ~clk;

  axis_client_tx dut (
    .clk                          (clk),
    .rst                          (rst),
    .client_tdata                 (client_tdata),
    .client_tlast                 (client_tlast),
    .client_valid                 (client_valid),
    .client_ready                 (client_ready),
    .axis_client_interface_tvalid (tvalid),
    .axis_client_interface_tlast  (tlast),
    .axis_client_interface_tdata  (tdata),
    .axis_client_interface_tready (tready),
    .words_sent                   (words),
    .pkts_sent                    (pkts),
    .err_forced_last              (err)
  );

  axis_client_tx #(.MAX_PKT_WORDS(4)) dut4 (
    .clk                          (clk),
    .rst                          (rst),
    .client_tdata                 (client_tdata),
    .client_tlast                 (client_tlast),
    .client_valid                 (client_valid),
    .client_ready                 (client_ready4),
    .axis_client_interface_tvalid (tvalid4),
    .axis_client_interface_tlast  (tlast4),
    .axis_client_interface_tdata  (tdata4),
    .axis_client_interface_tready (tready),
    .words_sent                   (words4),
    .pkts_sent                    (pkts4),
    .err_forced_last              (err4)
  );

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records handshakes just before the edge, then returns 1 time unit after it.
  task automatic tick(output bit pushed);
    logic last_m;
    @(negedge clk);
    pushed = 1'b0;
    if (!rst) begin
      mlen = 0;
    end else begin
      if (client_valid && client_ready) begin
        pushed = 1'b1;
        last_m = client_tlast || (mlen == 63);
        mlen   = last_m ? 0 : mlen + 1;
        exp_q.push_back({last_m, client_tdata});
      end
      if (tvalid && tready)  got_q.push_back({tlast, tdata[127:0]});
      if (tvalid4 && tready) got4_q.push_back({tlast4, tdata4[127:0]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit p;
    int idx, remaining, npk;
    logic [127:0] sum_exp, sum_got;

    // 1: reset held with client_valid high
    rst = 1'b0; client_valid = 1'b1; client_tdata = 128'haa; client_tlast = 1'b1;
    for (int c = 0; c < 3; c++) tick(p);
    chk("rst_ready", client_ready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata[127:0], 0);
    chk("rst_words", words, 0);
    chk("rst_pkts", pkts, 0);
    chk("rst_err", err, 0);
    rst = 1'b1; client_valid = 1'b0;
    chk("rel_ready_low", client_ready, 0);
    tick(p);
    chk("rel_ready_high", client_ready, 1);

    // 2: packet 5,7,9 with tready high
    tready = 1'b1; client_valid = 1'b1; client_tdata = 5; client_tlast = 1'b0;
    tick(p);
    chk("p2_latency", tvalid, 0);
    client_tdata = 7;
    tick(p);
    chk("p2_b0_valid", tvalid, 1);
    chk("p2_b0_data", tdata[127:0], 5);
    chk("p2_b0_last", tlast, 0);
    client_tdata = 9; client_tlast = 1'b1;
    tick(p);
    chk("p2_b1_data", tdata[127:0], 7);
    chk("p2_b1_last", tlast, 0);
    client_valid = 1'b0;
    tick(p);
    chk("p2_b2_data", tdata[127:0], 9);
    chk("p2_b2_last", tlast, 1);
    chk("p2_hi_zero", |tdata[511:128], 0);
    tick(p);
    chk("p2_idle_valid", tvalid, 0);
    chk("p2_tdata_kept", tdata[127:0], 9);
    chk("p2_words", words, 3);
    chk("p2_pkts", pkts, 1);

    // 3: backpressure, 20 words, tready low until the FIFO fills
    exp_q.delete(); got_q.delete(); got4_q.delete();
    tready = 1'b0; idx = 0; client_tdata = 100; client_tlast = 1'b0; client_valid = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick(p);
      if (p) begin
        idx++;
        client_tdata = 128'(100 + idx); client_tlast = (idx == 19); client_valid = (idx < 20);
      end
      if (c == 2) chk("bp_held_early", tdata[127:0], 100);
    end
    chk("bp_ready_low", client_ready, 0);
    chk("bp_accepted", exp_q.size(), 17);
    chk("bp_held_valid", tvalid, 1);
    chk("bp_held_data", tdata[127:0], 100);
    tready = 1'b1;
    for (int c = 0; c < 200 && got_q.size() < 20; c++) begin
      tick(p);
      if (p) begin
        idx++;
        client_tdata = 128'(100 + idx); client_tlast = (idx == 19); client_valid = (idx < 20);
      end
    end
    chk("bp_drained", got_q.size(), 20);
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      chk("bp_order", got_q[k], exp_q[k]);
      chk("bp_value", got_q[k][127:0], 128'(100 + k));
    end
    chk("bp_words", words, 23);
    chk("bp_pkts", pkts, 2);

    // 4: 4-word limit on dut4, 6 words without tlast
    rst = 1'b0; client_valid = 1'b0; tick(p);
    rst = 1'b1; tick(p);
    chk("lim_err_cleared", err4, 0);
    got4_q.delete();
    idx = 0; client_tlast = 1'b0; client_tdata = 1; client_valid = 1'b1;
    for (int c = 0; c < 60 && got4_q.size() < 6; c++) begin
      tick(p);
      if (p) begin idx++; client_tdata = 128'(1 + idx); client_valid = (idx < 6); end
    end
    chk("lim_count", got4_q.size(), 6);
    for (int k = 0; k < got4_q.size(); k++) begin
      chk("lim_data", got4_q[k][127:0], 128'(k + 1));
      chk("lim_last", got4_q[k][128], (k == 3));
    end
    tick(p);
    chk("lim_err", err4, 1);
    chk("lim_pkts", pkts4, 1);
    chk("lim_words", words4, 6);
    chk("lim_main_err", err, 0);

    // 5: reset after 2 of 4 beats accepted
    got_q.delete();
    tready = 1'b1; client_valid = 1'b1; client_tlast = 1'b0;
    for (int k = 0; k < 4; k++) begin
      client_tdata = 128'(11 + k); client_tlast = (k == 3);
      tick(p);
    end
    chk("mid_two_beats", got_q.size(), 2);
    rst = 1'b0; client_valid = 1'b0;
    tick(p);
    chk("mid_tvalid", tvalid, 0);
    chk("mid_pkts", pkts, 0);
    chk("mid_words", words, 0);
    rst = 1'b1;
    tick(p); tick(p);
    chk("mid_fifo_empty", tvalid, 0);
    client_valid = 1'b1; client_tdata = 128'h77; client_tlast = 1'b1;
    tick(p);
    client_valid = 1'b0;
    tick(p);
    chk("fresh_data", tdata[127:0], 128'h77);
    chk("fresh_last", tlast, 1);
    tick(p);
    chk("fresh_words", words, 1);
    chk("fresh_pkts", pkts, 1);

    // 6: random tready, 200 words in packets of 1..8
    exp_q.delete(); got_q.delete();
    idx = 0; npk = 0; sum_exp = '0; sum_got = '0;
    remaining = $urandom_range(1, 8);
    client_tdata = {$urandom, $urandom, $urandom, $urandom};
    client_tlast = (remaining == 1); client_valid = 1'b1;
    for (int c = 0; c < 3000 && !(idx == 200 && got_q.size() == 200); c++) begin
      tready = ($urandom % 2) != 0;
      tick(p);
      if (p) begin
        sum_exp += client_tdata;
        if (client_tlast) npk++;
        idx++; remaining--;
        if (remaining == 0) remaining = $urandom_range(1, 8);
        client_tdata = {$urandom, $urandom, $urandom, $urandom};
        client_tlast = (remaining == 1) || (idx == 199);
        client_valid = (idx < 200);
      end
    end
    chk("rnd_pushed", idx, 200);
    chk("rnd_received", got_q.size(), 200);
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      chk("rnd_order", got_q[k], exp_q[k]);
      sum_got += got_q[k][127:0];
    end
    chk("rnd_sum", sum_got, sum_exp);
    tick(p);
    chk("rnd_words", words, 201);
    chk("rnd_pkts", pkts, 16'(1 + npk));
    chk("rnd_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
